nios_rgb_capture_ctrl: RTL and testbench

NIOS_RGB_CAPTURE_CTRL -- requirements
Module: nios_rgb_capture_ctrl

---
 rtl/nios_rgb_capture_ctrl_pkg.sv | 28 ++
 rtl/nios_rgb_capture_ctrl_fifo.sv | 61 ++++++
 rtl/nios_rgb_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nios_rgb_capture_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_rgb_capture_ctrl_pkg.sv
// Shared definitions for the RGB capture controller: register map, CTRL/STATUS
// bit positions and the controller state encoding.
package nios_rgb_capture_ctrl_pkg;

    localparam int PIX_W = 24;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_DATA   = 2'd3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/nios_rgb_capture_ctrl_fifo.sv
// Synchronous pixel FIFO with flush; pointers carry one extra wrap bit so
// full/empty and the fill level come straight from their difference.
module nios_rgb_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              push_ok, pop_ok;

    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + LW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/nios_rgb_capture_ctrl.sv
// Avalon-MM controlled camera frame capture: arms on start, captures COUNT
// pixels from the first frame_start into a FIFO readable through DATA.
module nios_rgb_capture_ctrl
    import nios_rgb_capture_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int COUNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              frame_start,
    output logic              irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_q, irq_d;
    logic [31:0]        readdata_q, readdata_d;

    logic               wr_en, rd_en, start, abort, busy;
    logic               fifo_flush, fifo_push, fifo_pop;
    logic               fifo_full, fifo_empty;
    logic [PIX_W-1:0]   fifo_rdata;
    logic [LW-1:0]      fifo_level;
    logic [7:0]         level_byte;
    logic [31:0]        ctrl_rd, status_rd;
    logic               unused_wdata;

    assign wr_en        = chipselect && write;
    assign rd_en        = chipselect && read;
    assign start        = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START_BIT];
    assign abort        = wr_en && (address == ADDR_CTRL) && writedata[CTRL_ABORT_BIT];
    assign busy         = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
    assign unused_wdata = ^writedata;
    assign readdata     = readdata_q;
    assign irq          = irq_q;

    // A full 256-deep buffer does not fit the 8-bit level field, so saturate.
    assign level_byte = (32'(fifo_level) > 32'd255) ? 8'hFF : 8'(fifo_level);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        irq_en_d    = irq_en_q;
        fifo_flush  = 1'b0;
        fifo_push   = 1'b0;

        if (wr_en) begin
            case (address)
                ADDR_CTRL:   irq_en_d = writedata[CTRL_IRQ_EN_BIT];
                ADDR_STATUS: begin
                    if (writedata[STAT_DONE_BIT]) done_d     = 1'b0;
                    if (writedata[STAT_OVF_BIT])  overflow_d = 1'b0;
                end
                ADDR_COUNT:  count_d = writedata[COUNT_W-1:0];
                default: ;
            endcase
        end

        // Completion is evaluated after the W1C so a simultaneous set wins.
        if (abort) begin
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done_d      = 1'b0;
                        overflow_d  = 1'b0;
                        fifo_flush  = 1'b1;
                        remaining_d = count_q;
                        if (count_q == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ARM;
                        end
                    end
                end
                ST_ARM, ST_CAPTURE: begin
                    if (pix_valid && (frame_start || state_q == ST_CAPTURE)) begin
                        remaining_d = remaining_q - COUNT_W'(1);
                        if (fifo_full) overflow_d = 1'b1;
                        else           fifo_push  = 1'b1;
                        if (remaining_q == COUNT_W'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign fifo_pop = rd_en && (address == ADDR_DATA) && !fifo_empty && !fifo_flush;

    always_comb begin
        ctrl_rd                             = '0;
        ctrl_rd[CTRL_IRQ_EN_BIT]            = irq_en_q;
        status_rd                           = '0;
        status_rd[STAT_BUSY_BIT]            = busy;
        status_rd[STAT_DONE_BIT]            = done_q;
        status_rd[STAT_OVF_BIT]             = overflow_q;
        status_rd[STAT_LEVEL_LSB +: 8]      = level_byte;
        readdata_d                          = '0;
        if (rd_en) begin
            case (address)
                ADDR_CTRL:   readdata_d = ctrl_rd;
                ADDR_STATUS: readdata_d = status_rd;
                ADDR_COUNT:  readdata_d = 32'(count_q);
                ADDR_DATA:   readdata_d = fifo_empty ? 32'h0 : {8'h00, fifo_rdata};
                default:     readdata_d = '0;
            endcase
        end
        irq_d = done_q && irq_en_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            readdata_q  <= readdata_d;
        end
    end

    nios_rgb_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (pix_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_nios_rgb_capture_ctrl.sv
// Bench for nios_rgb_capture_ctrl: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model.
module tb_nios_rgb_capture_ctrl;

    localparam int DEPTH   = 16;
    localparam int COUNT_W = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pix_valid, frame_start;
    logic [23:0] pix_data;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    nios_rgb_capture_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .COUNT_W    (COUNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pixel queue plus a handful of flags describing the capture job.
    bit          m_wait_sof, m_active, m_done, m_ovf, m_irq_en, m_irq;
    logic [15:0] m_count;
    int          m_rem;
    logic [23:0] m_q[$];
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_wait_sof = 0; m_active = 0; m_done = 0; m_ovf = 0;
        m_irq_en = 0; m_irq = 0; m_count = 0; m_rem = 0;
        m_q.delete(); m_rdata = 0;
    endtask

    task automatic model_step();
        bit wr      = chipselect && write;
        bit rd      = chipselect && read;
        bit start   = wr && address == 2'd0 && writedata[0];
        bit abort   = wr && address == 2'd0 && writedata[1];
        bit busy    = m_wait_sof || m_active;
        bit full    = (m_q.size() == DEPTH);
        bit flush   = 0;
        bit push    = 0;
        bit pop     = rd && address == 2'd3 && m_q.size() > 0;
        int lvl     = m_q.size();
        logic [15:0] cnt = m_count;

        m_irq   = m_done && m_irq_en;
        m_rdata = 0;
        if (rd) begin
            case (address)
                2'd0: m_rdata = {29'd0, m_irq_en, 2'd0};
                2'd1: m_rdata = {16'd0, 8'(lvl), 5'd0, m_ovf, m_done, busy};
                2'd2: m_rdata = {16'd0, m_count};
                default: m_rdata = (lvl > 0) ? {8'h00, m_q[0]} : 32'h0;
            endcase
        end
        if (wr && address == 2'd0) m_irq_en = writedata[2];
        if (wr && address == 2'd1) begin
            if (writedata[1]) m_done = 0;
            if (writedata[2]) m_ovf  = 0;
        end
        if (wr && address == 2'd2) m_count = writedata[15:0];

        if (abort) begin
            m_wait_sof = 0; m_active = 0; m_done = 0; flush = 1;
        end else if (start && !busy) begin
            m_done = 0; m_ovf = 0; flush = 1; m_rem = int'(cnt);
            if (cnt == 0) m_done = 1;
            else          m_wait_sof = 1;
        end else if (pix_valid && (m_active || (m_wait_sof && frame_start))) begin
            m_rem--;
            if (full) m_ovf = 1;
            else      push  = 1;
            m_wait_sof = 0;
            m_active   = (m_rem != 0);
            if (m_rem == 0) m_done = 1;
        end

        if (flush) m_q.delete();
        else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(pix_data);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("readdata", readdata, m_rdata);
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic drive(input bit cs, input bit rd, input bit wr, input logic [1:0] a,
                         input logic [31:0] wd, input bit pv, input bit sof, input logic [23:0] pd);
        chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
        pix_valid = pv; frame_start = sof; pix_data = pd;
        step();
        chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
        pix_valid = 0; frame_start = 0; pix_data = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        drive(1, 0, 1, a, wd, 0, 0, 24'h0);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] val);
        drive(1, 1, 0, a, 32'h0, 0, 0, 24'h0);
        val = readdata;
    endtask

    task automatic pixel(input bit sof, input logic [23:0] pd);
        drive(0, 0, 0, 2'd0, 32'h0, 1, sof, pd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'd0, 32'h0, 0, 0, 24'h0);
    endtask

    task automatic drain();
        logic [31:0] v;
        for (int i = 0; i < DEPTH + 1; i++) bus_read(2'd3, v);
    endtask

    initial begin
        logic [31:0] v;
        logic [23:0] pix [4];
        pix[0] = 24'h112233; pix[1] = 24'h223344; pix[2] = 24'h334455; pix[3] = 24'h445566;

        reset_n = 0; chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
        pix_valid = 0; frame_start = 0; pix_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_irq", {31'd0, irq}, 32'h0);
        bus_read(2'd1, v); check_eq("rst_status", v, 32'h0);
        bus_read(2'd2, v); check_eq("rst_count", v, 32'h0);

        // Basic four-pixel frame
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h1);
        bus_read(2'd1, v); check_eq("arm_busy", v, 32'h1);
        for (int i = 0; i < 4; i++) pixel(i == 0, pix[i]);
        bus_read(2'd1, v); check_eq("four_status", v, 32'h0402);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd3, v); check_eq("four_data", v, {8'h00, pix[i]});
        end
        bus_read(2'd3, v); check_eq("empty_read", v, 32'h0);

        // Overflow: 20 pixels into a 16-deep buffer
        bus_write(2'd2, 32'd20);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 20; i++) pixel(i == 0, 24'($urandom));
        bus_read(2'd1, v); check_eq("ovf_status", v, 32'h1006);
        bus_write(2'd1, 32'h6);
        bus_read(2'd1, v); check_eq("ovf_w1c", v, 32'h1000);
        drain();

        // Pixels before frame_start are ignored
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 3; i++) pixel(0, 24'hABCDEF);
        bus_read(2'd1, v); check_eq("nosof_status", v, 32'h1);
        pixel(1, 24'h0A0B0C);
        bus_read(2'd1, v); check_eq("sof_status", v, 32'h0101);
        pixel(1, 24'h0D0E0F);
        bus_read(2'd1, v); check_eq("sof_done", v, 32'h0202);
        bus_read(2'd3, v); check_eq("sof_data0", v, 32'h000A0B0C);
        bus_read(2'd3, v); check_eq("sof_data1", v, 32'h000D0E0F);

        // Abort mid-frame, abort winning over start, then re-arm
        bus_write(2'd2, 32'd8);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 3; i++) pixel(i == 0, 24'(i + 1));
        bus_write(2'd0, 32'h2);
        bus_read(2'd1, v); check_eq("abort_status", v, 32'h0);
        bus_write(2'd0, 32'h3);
        bus_read(2'd1, v); check_eq("abort_wins", v, 32'h0);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h1);
        pixel(1, 24'h000077); pixel(0, 24'h000088);
        bus_read(2'd1, v); check_eq("rearm_status", v, 32'h0202);
        bus_read(2'd3, v); check_eq("rearm_data", v, 32'h00000077);
        drain();

        // Interrupt timing
        bus_write(2'd0, 32'h4);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'h5);
        pixel(1, 24'h123456);
        check_eq("irq_lag", {31'd0, irq}, 32'h0);
        idle();
        check_eq("irq_high", {31'd0, irq}, 32'h1);
        bus_write(2'd1, 32'h2);
        idle();
        check_eq("irq_cleared", {31'd0, irq}, 32'h0);

        // Completion beats a same-cycle done W1C
        bus_write(2'd0, 32'h5);
        drive(1, 0, 1, 2'd1, 32'h2, 1, 1, 24'h654321);
        bus_read(2'd1, v); check_eq("set_wins", v, 32'h0102);
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h6);
        drain();

        // Zero count completes at once
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h1);
        bus_read(2'd1, v); check_eq("zero_count", v, 32'h0002);

        // Reset pulse in the middle of a capture
        bus_write(2'd2, 32'd10);
        bus_write(2'd0, 32'h5);
        pixel(1, 24'h111111); pixel(0, 24'h222222);
        bus_read(2'd1, v); check_eq("pre_reset", v, 32'h0201);
        reset_n = 0;
        #2;
        check_eq("midrst_readdata", readdata, 32'h0);
        check_eq("midrst_irq", {31'd0, irq}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1;
        pixel(1, 24'h333333);
        bus_read(2'd1, v); check_eq("postrst_status", v, 32'h0);
        bus_read(2'd0, v); check_eq("postrst_ctrl", v, 32'h0);
        bus_read(2'd2, v); check_eq("postrst_count", v, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit          pv  = ($urandom_range(0, 1) == 1);
            bit          sof = ($urandom_range(0, 6) == 0);
            bit          bus = ($urandom_range(0, 9) < 3);
            bit          rd  = ($urandom_range(0, 1) == 1);
            logic [1:0]  a   = 2'($urandom);
            logic [31:0] wd  = $urandom;
            if (!rd) begin
                case (a)
                    2'd0: wd = {wd[31:3], wd[2], ($urandom_range(0, 7) == 0), wd[0]};
                    2'd2: wd = {wd[31:16], 16'($urandom_range(0, 24))};
                    default: ;
                endcase
            end
            drive(bus, bus && rd, bus && !rd, a, wd, pv, sof, 24'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
